// File: rtl/mult_seq_ctrl.sv
// Sequential 32x32->64 MULT/MULTU controller using shift-add through a shared external CLA32.
// Signed operands are reduced to magnitudes first, and the product is negated afterwards, all through the same adder.
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [WIDTH-1:0] AddA,
    output logic [WIDTH-1:0] AddB,
    output logic             AddCin,
    input  logic [WIDTH-1:0] AddSum,
    input  logic             AddCout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEGA  = 3'd1,
        S_NEGB  = 3'd2,
        S_RUN   = 3'd3,
        S_FIXLO = 3'd4,
        S_FIXHI = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_signed;
    logic               r_c;
    logic               r_busy;
    logic               r_done;
    logic               w_last_iter;

    assign w_last_iter = (r_cnt == {CNT_W{1'b1}});

    // Adder operands are a pure decode of state; the result is consumed on the next edge.
    always_comb begin
        AddA   = '0;
        AddB   = '0;
        AddCin = 1'b0;
        case (r_state)
            S_NEGA: begin
                AddA   = ~r_mcand;
                AddCin = r_mcand[WIDTH-1];
            end
            S_NEGB: begin
                AddA   = ~r_lo;
                AddCin = r_lo[WIDTH-1];
            end
            S_RUN: begin
                AddA = r_hi;
                AddB = r_lo[0] ? r_mcand : '0;
            end
            S_FIXLO: begin
                AddA   = r_neg ? ~r_lo : r_lo;
                AddCin = r_neg;
            end
            S_FIXHI: begin
                AddA   = r_neg ? ~r_hi : r_hi;
                AddCin = r_neg & r_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_signed <= 1'b0;
            r_c      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_mcand  <= OpA;
                        r_lo     <= OpB;
                        r_hi     <= '0;
                        r_cnt    <= '0;
                        r_neg    <= Signed & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                        r_signed <= Signed;
                        r_busy   <= 1'b1;
                        r_state  <= Signed ? S_NEGA : S_RUN;
                    end
                end
                // 0x80000000 negates to itself and is then read as unsigned 2^31.
                S_NEGA: begin
                    if (r_mcand[WIDTH-1]) r_mcand <= AddSum;
                    r_state <= S_NEGB;
                end
                S_NEGB: begin
                    if (r_lo[WIDTH-1]) r_lo <= AddSum;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_hi  <= {AddCout, AddSum[WIDTH-1:1]};
                    r_lo  <= {AddSum[0], r_lo[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_iter) begin
                        r_state <= r_signed ? S_FIXLO : S_DONE;
                        r_done  <= ~r_signed;
                    end
                end
                S_FIXLO: begin
                    r_lo    <= AddSum;
                    r_c     <= AddCout;
                    r_state <= S_FIXHI;
                end
                S_FIXHI: begin
                    r_hi    <= AddSum;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign Hi   = r_hi;
    assign Lo   = r_lo;

endmodule
